// File: rtl/code_scan_sequencer_pkg.sv
// Shared types and constant maps for the code scan sequencer and its code map.
package code_scan_sequencer_pkg;

    localparam int NUM_CODES = 8;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DWELL,
        FIN
    } state_t;

    localparam logic [6:0] GRAY_MAP [NUM_CODES] = '{
        7'b0000000, 7'b0000001, 7'b0000011, 7'b0000010,
        7'b0000110, 7'b0000111, 7'b0000101, 7'b0000100
    };

    localparam logic [6:0] SHIFT_MAP [NUM_CODES] = '{
        7'b0000000, 7'b0000001, 7'b0000010, 7'b0000100,
        7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000
    };

endpackage

// File: rtl/code_map.sv
// Combinational 3-bit to 7-bit pattern map; the caller registers the result.
module code_map
    import code_scan_sequencer_pkg::*;
(
    input  logic [2:0] code,
    input  logic       mode,
    output logic [6:0] enc
);

    assign enc = mode ? GRAY_MAP[code] : SHIFT_MAP[code];

endmodule

// File: rtl/code_scan_sequencer.sv
// Steps a 3-bit code through all eight values and offers each mapped pattern
// on a valid/ready handshake, with an optional dwell gap between codes.
module code_scan_sequencer
    import code_scan_sequencer_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic               wrap,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [2:0]         code,
    output logic [6:0]         enc,
    output logic               busy,
    output logic               done
);

    state_t             state_reg, state_next;
    logic [2:0]         code_reg, code_next;
    logic [6:0]         enc_reg, enc_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic               mode_reg, mode_next;
    logic               dir_reg, dir_next;
    logic               wrap_reg, wrap_next;
    logic               out_valid_reg, busy_reg, done_reg;
    logic [2:0]         adv_code;
    logic [2:0]         last_code;
    logic               handshake;

    assign adv_code  = dir_reg ? code_reg - 3'd1 : code_reg + 3'd1;
    assign last_code = dir_reg ? 3'd0 : 3'(NUM_CODES - 1);
    assign handshake = out_valid_reg && out_ready;

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        cnt_next   = cnt_reg;
        dwell_next = dwell_reg;
        mode_next  = mode_reg;
        dir_next   = dir_reg;
        wrap_next  = wrap_reg;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = EMIT;
                    mode_next  = mode;
                    dir_next   = dir;
                    wrap_next  = wrap;
                    dwell_next = dwell;
                    code_next  = dir ? 3'(NUM_CODES - 1) : 3'd0;
                end
            end
            EMIT: begin
                // stop wins over a coincident handshake: the code is consumed but not advanced
                if (stop) begin
                    state_next = IDLE;
                end else if (handshake) begin
                    if (!wrap_reg && code_reg == last_code) begin
                        state_next = FIN;
                    end else if (dwell_reg == '0) begin
                        code_next = adv_code;
                    end else begin
                        state_next = DWELL;
                        cnt_next   = dwell_reg;
                    end
                end
            end
            DWELL: begin
                if (stop) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DWELL_W'(1)) begin
                    state_next = EMIT;
                    code_next  = adv_code;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Map the next code under the next mode so enc always lands with its code.
    code_map u_code_map (
        .code (code_next),
        .mode (mode_next),
        .enc  (enc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            code_reg      <= '0;
            enc_reg       <= '0;
            cnt_reg       <= '0;
            dwell_reg     <= '0;
            mode_reg      <= 1'b0;
            dir_reg       <= 1'b0;
            wrap_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            enc_reg       <= enc_next;
            cnt_reg       <= cnt_next;
            dwell_reg     <= dwell_next;
            mode_reg      <= mode_next;
            dir_reg       <= dir_next;
            wrap_reg      <= wrap_next;
            out_valid_reg <= (state_next == EMIT);
            busy_reg      <= (state_next == EMIT) || (state_next == DWELL);
            done_reg      <= (state_next == FIN);
        end
    end

    assign out_valid = out_valid_reg;
    assign code      = code_reg;
    assign enc       = enc_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_code_scan_sequencer.sv
// Randomized self-checking bench for code_scan_sequencer against a sequence-level model.
module tb_code_scan_sequencer;

    localparam int DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               mode = 1'b0;
    logic               dir = 1'b0;
    logic               wrap = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [2:0]         code;
    logic [6:0]         enc;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    code_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dir       (dir),
        .wrap      (wrap),
        .dwell     (dwell),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .code      (code),
        .enc       (enc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // k-th code of a scan: counting from 0 upward or from 7 downward, modulo 8
    function automatic int model_code(input logic d, input int k);
        return d ? (7 - (k % 8)) : (k % 8);
    endfunction

    // gray-style map is the reflected Gray code; shift map is a walking one above code 0
    function automatic logic [6:0] model_enc(input logic m, input int c);
        if (m) return 7'(c ^ (c >> 1));
        return (c == 0) ? 7'd0 : 7'(1 << (c - 1));
    endfunction

    // Runs a scan of nhs handshakes; stall_k holds ready low 5 cycles at that index.
    task automatic scan(input logic m, input logic d, input logic w, input int dw,
                        input int rdy_pct, input int nhs, input int stall_k);
        int  k, gap, cyc, stall_cnt, exp_c, exp_cyc;
        bit  after_hs;
        @(negedge clk);
        mode = m; dir = d; wrap = w; dwell = DWELL_W'(dw); start = 1'b1; stop = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        // configuration changes after start accept must have no effect
        mode = 1'($urandom); dir = 1'($urandom); wrap = 1'($urandom); dwell = DWELL_W'($urandom);
        k = 0; gap = 0; cyc = 0; stall_cnt = 0; after_hs = 0;
        while (k < nhs && cyc < 2000) begin
            cyc++;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL scan_status k=%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
            end
            if (out_valid === 1'b1) begin
                exp_c = model_code(d, k);
                if (after_hs) begin
                    checks++;
                    if (gap != dw) begin
                        errors++;
                        $display("FAIL dwell_gap k=%0d gap=%0d required %0d", k, gap, dw);
                    end
                end
                checks++;
                if (code !== 3'(exp_c) || enc !== model_enc(m, exp_c)) begin
                    errors++;
                    $display("FAIL scan_value k=%0d code=%0d enc=%h required code=%0d enc=%h",
                             k, code, enc, exp_c, model_enc(m, exp_c));
                end
                after_hs = 0;
                if (k == stall_k && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = ($urandom_range(99) < rdy_pct);
                end
                if (out_ready) begin
                    k++;
                    after_hs = 1;
                    gap = 0;
                end
            end else begin
                out_ready = 1'($urandom);
                if (after_hs) gap++;
            end
            @(negedge clk);
        end
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL scan_timeout handshakes=%0d required %0d", k, nhs);
        end
        if (rdy_pct == 100) begin
            exp_cyc = nhs + (nhs - 1) * dw + ((stall_k >= 0) ? 5 : 0);
            checks++;
            if (cyc != exp_cyc) begin
                errors++;
                $display("FAIL throughput cycles=%0d required %0d", cyc, exp_cyc);
            end
        end
        if (!w && nhs == 8) begin
            exp_c = model_code(d, 7);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || code !== 3'(exp_c)) begin
                errors++;
                $display("FAIL fin_pulse done=%b busy=%b valid=%b code=%0d required 1 0 0 %0d",
                         done, busy, out_valid, code, exp_c);
            end
            start = 1'b1;  // ignored in FIN
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || code !== 3'(exp_c)) begin
                errors++;
                $display("FAIL fin_to_idle done=%b busy=%b valid=%b code=%0d required 0 0 0 %0d",
                         done, busy, out_valid, code, exp_c);
            end
        end
        $display("scan mode=%0d dir=%0d wrap=%0d dwell=%0d handshakes=%0d cycles=%0d",
                 m, d, w, dw, k, cyc);
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || code !== 3'd0 || enc !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset valid=%b code=%0d enc=%h busy=%b done=%b required all zero",
                     out_valid, code, enc, busy, done);
        end
        $display("reset checked");
    endtask

    task automatic test_single_gray();
        scan(1'b1, 1'b0, 1'b0, 0, 100, 8, -1);
    endtask

    task automatic test_shift_down_dwell();
        scan(1'b0, 1'b1, 1'b0, 2, 100, 8, -1);
    endtask

    task automatic test_ready_stall();
        scan(1'b1, 1'b0, 1'b0, 0, 100, 8, 3);
    endtask

    task automatic test_random_scans();
        for (int i = 0; i < 4; i++)
            scan(1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(3)), 60, 8, -1);
    endtask

    task automatic test_wrap_stop();
        scan(1'b1, 1'b0, 1'b1, 0, 100, 20, -1);
        stop = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || code !== 3'd4) begin
            errors++;
            $display("FAIL wrap_stop valid=%b busy=%b done=%b code=%0d required 0 0 0 4",
                     out_valid, busy, done, code);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_stop_done done=%b required 0", done);
        end
        $display("wrap stop code=%0d", code);
    endtask

    task automatic test_stop_handshake();
        scan(1'b1, 1'b0, 1'b0, 0, 100, 5, -1);
        stop = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || code !== 3'd5 || enc !== model_enc(1'b1, 5)) begin
            errors++;
            $display("FAIL stop_handshake valid=%b busy=%b done=%b code=%0d enc=%h required 0 0 0 5 %h",
                     out_valid, busy, done, code, enc, model_enc(1'b1, 5));
        end
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || code !== 3'd5) begin
            errors++;
            $display("FAIL start_with_stop valid=%b busy=%b code=%0d required 0 0 5", out_valid, busy, code);
        end
        $display("stop with handshake code=%0d", code);
    endtask

    task automatic test_async_reset();
        scan(1'b0, 1'b0, 1'b0, 3, 100, 2, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || code !== 3'd0 || enc !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%b code=%0d enc=%h busy=%b done=%b required all zero",
                     out_valid, code, enc, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset in dwell");
        scan(1'b1, 1'b0, 1'b0, 0, 100, 8, -1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_single_gray();
        test_shift_down_dwell();
        test_ready_stall();
        test_random_scans();
        test_wrap_stop();
        test_stop_handshake();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
